// File: rtl/music_sequencer.sv
// Song ROM walker: fetches one note per tempo tick and drives the decoder index.
// Optional build macro SEQ_LOOP_EN: the song repeats instead of stopping with a DONE pulse.
module music_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int SONG_LEN = 139
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic [3:0]        rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [3:0]        inx,
  output logic              playing,
  output logic              done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_PAUSED = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  logic [2:0] state;
  logic       tick_pend;
  logic       pause_pend;
  logic [3:0] saved_note;

  assign playing = (state == S_FETCH) || (state == S_LOAD) || (state == S_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rom_addr   <= '0;
      inx        <= 4'd0;
      done       <= 1'b0;
      tick_pend  <= 1'b0;
      pause_pend <= 1'b0;
      saved_note <= 4'd0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state      <= S_IDLE;
        rom_addr   <= '0;
        inx        <= 4'd0;
        tick_pend  <= 1'b0;
        pause_pend <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            inx <= 4'd0;
            if (play && !pause) state <= S_FETCH;
          end
          S_FETCH: begin
            if (tick)  tick_pend  <= 1'b1;
            if (pause) pause_pend <= 1'b1;
            state <= S_LOAD;
          end
          S_LOAD: begin
            if (tick)  tick_pend  <= 1'b1;
            if (pause) pause_pend <= 1'b1;
            saved_note <= rom_data;
            inx        <= rom_data;
            state      <= S_HOLD;
          end
          S_HOLD: begin
            // A pause requested during the fetch wins over a tick caught there; the tick is kept.
            if (pause || pause_pend) begin
              pause_pend <= 1'b0;
              inx        <= 4'd0;
              state      <= S_PAUSED;
            end else if (tick || tick_pend) begin
              tick_pend <= 1'b0;
              if (rom_addr == LAST_ADDR) begin
                rom_addr <= '0;
`ifdef SEQ_LOOP_EN
                state    <= S_FETCH;
`else
                inx      <= 4'd0;
                done     <= 1'b1;
                state    <= S_IDLE;
`endif
              end else begin
                rom_addr <= rom_addr + 1'b1;
                state    <= S_FETCH;
              end
            end
          end
          S_PAUSED: begin
            if (play && !pause) begin
              inx   <= saved_note;
              state <= S_HOLD;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer: two instances (4-note and 1-note songs) checked cycle by cycle
// against a note-timing reference model under directed and random control stimulus.
module tb_music_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, play, pause, stop;
  logic [3:0] rom_data_w [2];
  logic [7:0] rom_addr_w [2];
  logic [3:0] inx_w      [2];
  logic       playing_w  [2];
  logic       done_w     [2];
  logic [3:0] rom_mem    [2][256];

  always #5 clk = ~clk;

  music_sequencer #(.ADDR_W(8), .SONG_LEN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .play(play), .pause(pause), .stop(stop),
    .rom_data(rom_data_w[0]), .rom_addr(rom_addr_w[0]), .inx(inx_w[0]),
    .playing(playing_w[0]), .done(done_w[0]));

  music_sequencer #(.ADDR_W(8), .SONG_LEN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .play(play), .pause(pause), .stop(stop),
    .rom_data(rom_data_w[1]), .rom_addr(rom_addr_w[1]), .inx(inx_w[1]),
    .playing(playing_w[1]), .done(done_w[1]));

  // Synchronous song ROMs
  always @(posedge clk) begin
    rom_data_w[0] <= rom_mem[0][rom_addr_w[0]];
    rom_data_w[1] <= rom_mem[1][rom_addr_w[1]];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: mode 0 stopped, 1 running, 2 paused. While running, lat counts the
  // cycles until the fetched note reaches the decoder (2 = ROM being read, 0 = note sounding).
  int song_len [2] = '{4, 1};
  int m_addr [2], m_inx [2], m_mode [2], m_lat [2], m_saved [2];
  bit m_done [2], m_tp [2], m_pp [2];

  function automatic void model_reset(int k);
    m_addr[k] = 0; m_inx[k] = 0; m_mode[k] = 0; m_lat[k] = 0; m_saved[k] = 0;
    m_done[k] = 0; m_tp[k] = 0; m_pp[k] = 0;
  endfunction

  function automatic void model_step(int k);
    m_done[k] = 0;
    if (!rst_n) begin
      model_reset(k);
    end else if (stop) begin
      m_mode[k] = 0; m_addr[k] = 0; m_inx[k] = 0; m_lat[k] = 0; m_tp[k] = 0; m_pp[k] = 0;
    end else if (m_mode[k] == 0) begin
      m_inx[k] = 0;
      if (play && !pause) begin m_mode[k] = 1; m_lat[k] = 2; end
    end else if (m_mode[k] == 1 && m_lat[k] > 0) begin
      if (tick)  m_tp[k] = 1;
      if (pause) m_pp[k] = 1;
      if (m_lat[k] == 1) begin
        m_inx[k]   = int'(rom_mem[k][m_addr[k]]);
        m_saved[k] = m_inx[k];
      end
      m_lat[k]--;
    end else if (m_mode[k] == 1) begin
      if (pause || m_pp[k]) begin
        m_pp[k] = 0; m_mode[k] = 2; m_inx[k] = 0;
      end else if (tick || m_tp[k]) begin
        m_tp[k] = 0;
        if (m_addr[k] == song_len[k] - 1) begin
          m_addr[k] = 0;
`ifdef SEQ_LOOP_EN
          m_lat[k] = 2;
`else
          m_inx[k] = 0; m_done[k] = 1; m_mode[k] = 0;
`endif
        end else begin
          m_addr[k]++; m_lat[k] = 2;
        end
      end
    end else begin
      m_inx[k] = 0;
      if (play && !pause) begin m_mode[k] = 1; m_lat[k] = 0; m_inx[k] = m_saved[k]; end
    end
  endfunction

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rom_addr%0d", k), 32'(rom_addr_w[k]), 32'(m_addr[k]));
      chk($sformatf("inx%0d", k), 32'(inx_w[k]), 32'(m_inx[k]));
      chk($sformatf("playing%0d", k), 32'(playing_w[k]), 32'(m_mode[k] == 1));
      chk($sformatf("done%0d", k), 32'(done_w[k]), 32'(m_done[k]));
    end
  endtask

  int tick_per = 10;
  int tcnt = 0;

  // One clock: choose tick, advance the model with the inputs seen at the edge, then compare.
  task automatic cyc();
    if (tick_per > 0) tick = ((tcnt % tick_per) == 0);
    else              tick = ($urandom_range(0, 3) == 0);
    tcnt++;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    compare_all();
    tick = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_play();
    play = 1'b1; cyc(); play = 1'b0;
  endtask

  // Advance until the 4-note model reaches addr with the note sounding (lat 0) or just fetching (lat 2).
  task automatic wait_for(input int addr, input int lat, input int limit);
    int n = 0;
    while (!(m_mode[0] == 1 && m_addr[0] == addr && m_lat[0] == lat) && n < limit) begin
      cyc();
      n++;
    end
    if (n >= limit) chk("wait_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (%0d checks so far)", n_chk);
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 256; a++) begin rom_mem[0][a] = 4'd0; rom_mem[1][a] = 4'd0; end
    rom_mem[0][0] = 4'd3; rom_mem[0][1] = 4'd5; rom_mem[0][2] = 4'd0; rom_mem[0][3] = 4'd8;
    rom_mem[1][0] = 4'd7;
    model_reset(0); model_reset(1);
    rst_n = 1'b0; tick = 1'b0; play = 1'b0; pause = 1'b0; stop = 1'b0;
    run(3);
    #2 rst_n = 1'b1;

    // Whole song at a 10-cycle tempo, then past its end
    pulse_play();
    run(60);

    // Pause during note 5 for 25 cycles, then resume
    pulse_play();
    wait_for(1, 0, 100);
    pause = 1'b1; run(25); pause = 1'b0;
    chk("paused_inx", 32'(inx_w[0]), 32'(0));
    chk("paused_playing", 32'(playing_w[0]), 32'(0));
    play = 1'b1; pause = 1'b1; run(3); pause = 1'b0;
    cyc(); play = 1'b0;
    chk("resume_inx", 32'(inx_w[0]), 32'(5));
    chk("resume_addr", 32'(rom_addr_w[0]), 32'(1));
    run(30);

    // Fast tempo so ticks land in fetch/load and are carried over
    tick_per = 3; run(40);
    tick_per = 2; run(40);
    tick_per = 10;

    // Stop with pause and play asserted at addr 2, then restart
    stop = 1'b1; run(2); stop = 1'b0;
    pulse_play();
    wait_for(2, 0, 100);
    stop = 1'b1; pause = 1'b1; play = 1'b1; cyc();
    stop = 1'b0; pause = 1'b0; play = 1'b0;
    chk("stop_inx", 32'(inx_w[0]), 32'(0));
    chk("stop_addr", 32'(rom_addr_w[0]), 32'(0));
    chk("stop_done", 32'(done_w[0]), 32'(0));
    pulse_play();
    run(2);
    chk("restart_inx", 32'(inx_w[0]), 32'(3));

    // Asynchronous reset in the middle of the fetch at addr 2
    wait_for(2, 2, 100);
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("async_addr%0d", k), 32'(rom_addr_w[k]), 32'(0));
      chk($sformatf("async_inx%0d", k), 32'(inx_w[k]), 32'(0));
      chk($sformatf("async_playing%0d", k), 32'(playing_w[k]), 32'(0));
      chk($sformatf("async_done%0d", k), 32'(done_w[k]), 32'(0));
    end
    model_reset(0); model_reset(1);
    run(2);
    #2 rst_n = 1'b1;
    run(5);

    // Random control traffic
    tick_per = 0;
    for (int i = 0; i < 4000; i++) begin
      play  = ($urandom_range(0, 9) == 0);
      pause = ($urandom_range(0, 24) == 0);
      stop  = ($urandom_range(0, 79) == 0);
      cyc();
    end
    play = 1'b0; pause = 1'b0; stop = 1'b0;
    run(5);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
